// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Pipeline sequencing controller for the 5-stage ARM core. Sits beside the ID
// stage and produces the freeze/flush controls for the PC and the pipeline
// registers:
//   - data hazard : freeze PC and IF/ID, bubble into ID/EX (hazard_stall)
//   - taken branch: flush IF/ID and ID/EX (if_flush, id_flush)
//   - memory wait : freeze the whole pipe while a multi-cycle load/store
//                   occupies the MEM stage (mem_freeze)
// It also keeps a saturating count of stalled cycles for performance analysis.
//
// Parameters
//   MEM_LAT      cycles a load/store occupies MEM (1..15, 1 = no freeze)
//   CNT_W        width of the stall statistics counter
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   src1         Rn index of the ID instruction
//   src2         Rm/Rd index of the ID instruction
//   two_src      ID instruction reads src2
//   src_valid    ID instruction reads src1
//   exe_dest     destination register of the EXE instruction
//   exe_wb_en    EXE instruction writes back
//   exe_mem_r_en EXE instruction is a load
//   mem_dest     destination register of the MEM instruction
//   mem_wb_en    MEM instruction writes back
//   mem_req      MEM instruction is a load or store
//   branch_taken branch resolved taken in EXE
//   fwd_en       forwarding unit enabled
//   clr_stats    synchronous clear of stall_count
//   hazard_stall freeze PC and IF/ID, bubble ID/EX
//   if_flush     flush IF/ID
//   id_flush     flush ID/EX
//   mem_freeze   freeze all pipeline registers and PC
//   mem_busy     memory FSM is in the busy state (registered)
//   stall_count  saturating count of cycles with hazard_stall or mem_freeze
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_LAT = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             two_src,
    input  logic             src_valid,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_req,
    input  logic             branch_taken,
    input  logic             fwd_en,
    input  logic             clr_stats,
    output logic             hazard_stall,
    output logic             if_flush,
    output logic             id_flush,
    output logic             mem_freeze,
    output logic             mem_busy,
    output logic [CNT_W-1:0] stall_count
);

    // A latency of 1 means the access completes in a single MEM cycle.
    localparam bit         MemWaitOn = (MEM_LAT > 1);
    // The IDLE cycle itself is the first freeze cycle, so the busy state only
    // has to cover MEM_LAT-2 more freeze cycles plus one release cycle.
    localparam logic [3:0] WaitInit  = MemWaitOn ? 4'(MEM_LAT - 2) : 4'd0;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic [CNT_W-1:0] count_q, count_d;

    // -----------------------------------------------------------------------
    // RAW hazard detection
    // -----------------------------------------------------------------------
    logic s1_exe, s2_exe, s1_mem, s2_mem;
    logic raw;

    always_comb begin
        s1_exe = src_valid & (src1 == exe_dest);
        s2_exe = two_src   & (src2 == exe_dest);
        s1_mem = src_valid & (src1 == mem_dest);
        s2_mem = two_src   & (src2 == mem_dest);
        raw    = 1'b0;
        if (fwd_en) begin
            // Forwarding covers everything except a load result still in EXE.
            raw = exe_mem_r_en & (s1_exe | s2_exe);
        end else begin
            raw = (exe_wb_en & (s1_exe | s2_exe)) | (mem_wb_en & (s1_mem | s2_mem));
        end
    end

    // -----------------------------------------------------------------------
    // Memory-wait FSM: next state and freeze
    // -----------------------------------------------------------------------
    logic freeze_int;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        freeze_int = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (MemWaitOn && mem_req) begin
                    freeze_int = 1'b1;
                    state_d    = StBusy;
                    wait_d     = WaitInit;
                end
            end
            StBusy: begin
                if (wait_q != 4'd0) begin
                    freeze_int = 1'b1;
                    wait_d     = wait_q - 4'd1;
                end else begin
                    // Release cycle: the pipe advances at this edge, so a
                    // following load/store is seen in IDLE with no gap.
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                wait_d  = 4'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Priority resolution
    // -----------------------------------------------------------------------
    // A frozen pipe holds its stage contents, so stalls and flushes are
    // simply deferred until the freeze drops. A taken branch flushes the
    // instruction that would otherwise stall, so the stall is dropped.
    logic hazard_int, flush_int;

    always_comb begin
        hazard_int = raw & ~branch_taken & ~freeze_int;
        flush_int  = branch_taken & ~freeze_int;
    end

    // All combinational controls are held low while reset is asserted.
    always_comb begin
        hazard_stall = rst & hazard_int;
        if_flush     = rst & flush_int;
        id_flush     = rst & flush_int;
        mem_freeze   = rst & freeze_int;
    end

    // -----------------------------------------------------------------------
    // Stall statistics counter
    // -----------------------------------------------------------------------
    // The ungated terms are used here; the register is held in reset anyway.
    always_comb begin
        count_d = count_q;
        if (clr_stats) begin
            count_d = '0;
        end else if ((hazard_int | freeze_int) && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            wait_q  <= 4'd0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        mem_busy    = (state_q == StBusy);
        stall_count = count_q;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl. Three instances share one stimulus:
//   d3: MEM_LAT=3, CNT_W=16   (main instance)
//   d4: MEM_LAT=4, CNT_W=4    (back-to-back freeze pattern, saturation)
//   d1: MEM_LAT=1, CNT_W=8    (no memory freeze)
// Combinational hazard/flush cases come from a vector table; multi-cycle
// behaviour is exercised by short hand-written sequences.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] src1, src2, exe_dest, mem_dest;
    logic       two_src, src_valid, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic       mem_req, branch_taken, fwd_en, clr_stats;

    logic        hs3, if3, id3, mf3, mb3;
    logic [15:0] sc3;
    logic        hs4, if4, id4, mf4, mb4;
    logic [3:0]  sc4;
    logic        hs1, if1, id1, mf1, mb1;
    logic [7:0]  sc1;

    int n_app = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_LAT(3), .CNT_W(16)) d3 (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .src_valid(src_valid), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .mem_req(mem_req), .branch_taken(branch_taken), .fwd_en(fwd_en),
        .clr_stats(clr_stats), .hazard_stall(hs3), .if_flush(if3), .id_flush(id3),
        .mem_freeze(mf3), .mem_busy(mb3), .stall_count(sc3)
    );

    pipe_hazard_ctrl #(.MEM_LAT(4), .CNT_W(4)) d4 (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .src_valid(src_valid), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .mem_req(mem_req), .branch_taken(branch_taken), .fwd_en(fwd_en),
        .clr_stats(clr_stats), .hazard_stall(hs4), .if_flush(if4), .id_flush(id4),
        .mem_freeze(mf4), .mem_busy(mb4), .stall_count(sc4)
    );

    pipe_hazard_ctrl #(.MEM_LAT(1), .CNT_W(8)) d1 (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .src_valid(src_valid), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .mem_req(mem_req), .branch_taken(branch_taken), .fwd_en(fwd_en),
        .clr_stats(clr_stats), .hazard_stall(hs1), .if_flush(if1), .id_flush(id1),
        .mem_freeze(mf1), .mem_busy(mb1), .stall_count(sc1)
    );

    typedef struct {
        logic       fwd;
        logic       sv;
        logic       ts;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [3:0] ed;
        logic       ewb;
        logic       emr;
        logic [3:0] md;
        logic       mwb;
        logic       bt;
        logic       exp_stall;
        logic       exp_flush;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_app++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        src1 = 4'd0; src2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
        two_src = 1'b0; src_valid = 1'b0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_wb_en = 1'b0; mem_req = 1'b0; branch_taken = 1'b0; fwd_en = 1'b0;
        clr_stats = 1'b0;
    endtask

    task automatic load_use();
        fwd_en = 1'b1; src_valid = 1'b1; src1 = 4'd5; exe_dest = 4'd5;
        exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    endtask

    initial begin
        // fwd sv ts s1 s2 ed ewb emr md mwb bt | stall flush
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'd5,  4'd0, 4'd5, 1'b1, 1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'd5,  4'd0, 4'd5, 1'b1, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 4'd5,  4'd5, 4'd5, 1'b1, 1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 4'd5,  4'd0, 4'd5, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 4'd6,  4'd7, 4'd5, 1'b1, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd3, 4'd9, 1'b0, 1'b0, 4'd3,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd3, 4'd9, 1'b0, 1'b0, 4'd3,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'd7,  4'd0, 4'd7, 1'b1, 1'b0, 4'd3,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'd7,  4'd0, 4'd7, 1'b0, 1'b0, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 4'd0,  4'd3, 4'd9, 1'b0, 1'b0, 4'd3,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 4'd5,  4'd0, 4'd5, 1'b1, 1'b1, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd0, 4'd0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd0, 4'd4, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 4'd15, 4'd0, 4'd4, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 4'd7,  4'd0, 4'd7, 1'b1, 1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0};

        // ---------------- reset: every output low despite active inputs
        rst = 1'b0;
        clear_inputs();
        load_use();
        mem_req = 1'b1;
        branch_taken = 1'b1;
        tick();
        tick();
        check("rst d3 hazard_stall", hs3, 0);
        check("rst d3 if_flush",     if3, 0);
        check("rst d3 id_flush",     id3, 0);
        check("rst d3 mem_freeze",   mf3, 0);
        check("rst d3 mem_busy",     mb3, 0);
        check("rst d3 stall_count",  sc3, 0);
        check("rst d4 outputs", {hs4, if4, id4, mf4, mb4, sc4}, 0);
        check("rst d1 outputs", {hs1, if1, id1, mf1, mb1, sc1}, 0);

        // ---------------- single memory access, MEM_LAT=3
        clear_inputs();
        rst = 1'b1;
        tick();
        mem_req = 1'b1;
        #2;
        check("mem1 c0 mem_freeze", mf3, 1);
        check("mem1 c0 mem_busy",   mb3, 0);
        tick();
        mem_req = 1'b0;
        #2;
        check("mem1 c1 mem_freeze", mf3, 1);
        check("mem1 c1 mem_busy",   mb3, 1);
        tick();
        check("mem1 c2 mem_freeze", mf3, 0);
        check("mem1 c2 mem_busy",   mb3, 1);
        tick();
        check("mem1 c3 mem_busy",    mb3, 0);
        check("mem1 c3 stall_count", sc3, 2);
        check("mem1 d1 mem_busy",    mb1, 0);

        // ---------------- combinational hazard / branch table
        repeat (4) tick();
        for (int i = 0; i < 15; i++) begin
            fwd_en = vecs[i].fwd;  src_valid = vecs[i].sv;  two_src = vecs[i].ts;
            src1 = vecs[i].s1;     src2 = vecs[i].s2;       exe_dest = vecs[i].ed;
            exe_wb_en = vecs[i].ewb; exe_mem_r_en = vecs[i].emr;
            mem_dest = vecs[i].md; mem_wb_en = vecs[i].mwb; branch_taken = vecs[i].bt;
            #2;
            check($sformatf("vec%0d hazard_stall", i), hs3, vecs[i].exp_stall);
            check($sformatf("vec%0d if_flush", i),     if3, vecs[i].exp_flush);
            check($sformatf("vec%0d id_flush", i),     id3, vecs[i].exp_flush);
            check($sformatf("vec%0d d1 hazard_stall", i), hs1, vecs[i].exp_stall);
            tick();
        end

        // ---------------- priority: freeze defers branch flush and stall
        clear_inputs();
        tick();
        load_use();
        branch_taken = 1'b1;
        mem_req = 1'b1;
        #2;
        check("prio c0 mem_freeze",   mf3, 1);
        check("prio c0 hazard_stall", hs3, 0);
        check("prio c0 if_flush",     if3, 0);
        check("prio c0 id_flush",     id3, 0);
        check("prio d1 mem_freeze",   mf1, 0);
        check("prio d1 if_flush",     if1, 1);
        check("prio d1 id_flush",     id1, 1);
        tick();
        check("prio c1 mem_freeze",   mf3, 1);
        check("prio c1 flush/stall",  {hs3, if3, id3}, 0);
        tick();
        check("prio c2 mem_freeze",   mf3, 0);
        check("prio c2 hazard_stall", hs3, 0);
        check("prio c2 if_flush",     if3, 1);
        check("prio c2 id_flush",     id3, 1);
        clear_inputs();
        repeat (5) tick();

        // ---------------- back-to-back memory, MEM_LAT=4
        begin
            logic [7:0] pat;
            pat = 8'b0111_0111;  // bit i = expected freeze in cycle i
            mem_req = 1'b1;
            for (int i = 0; i < 8; i++) begin
                #2;
                check($sformatf("b2b c%0d mem_freeze", i), mf4, 32'(pat[i]));
                tick();
            end
        end
        tick();
        check("b2b busy before rst", mb4, 1);
        check("b2b freeze before rst", mf4, 1);
        rst = 1'b0;
        #1;
        check("b2b rst mem_freeze", mf4, 0);
        check("b2b rst mem_busy",   mb4, 0);
        clear_inputs();
        tick();
        rst = 1'b1;
        tick();

        // ---------------- counter saturation and clear
        load_use();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("cnt cleared d3", sc3, 0);
        repeat (20) tick();
        check("cnt d3 after 20", sc3, 20);
        check("cnt d4 saturated", sc4, 15);
        clr_stats = 1'b1;
        tick();
        check("cnt clr d3", sc3, 0);
        check("cnt clr d4", sc4, 0);
        clr_stats = 1'b0;
        tick();
        check("cnt resume d3", sc3, 1);
        check("cnt resume d4", sc4, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_app, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage ARM core.
- Generates three control classes:
  - freeze of PC and IF/ID on a data hazard, plus bubble insertion into the ID/EX register;
  - flush of IF/ID and ID/EX on a taken branch;
  - whole-pipe freeze while a multi-cycle data-memory access completes.
- Sits beside the ID stage. Inputs are ID source registers plus EXE/MEM stage control fields. Outputs drive the pipeline-register freeze and flush pins.
- Also keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- MEM_LAT, 3, cycles an instruction occupies the MEM stage per load/store; legal range 1..15. A value of 1 means no memory freeze.
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- src1  in  4  Rn index of the instruction in ID
- src2  in  4  Rm/Rd index of the instruction in ID
- two_src  in  1  ID instruction reads src2
- src_valid  in  1  ID instruction reads src1 (low for B, MOV, MVN)
- exe_dest  in  4  destination register of the instruction in EXE
- exe_wb_en  in  1  EXE instruction writes back
- exe_mem_r_en  in  1  EXE instruction is a load
- mem_dest  in  4  destination register of the instruction in MEM
- mem_wb_en  in  1  MEM instruction writes back
- mem_req  in  1  MEM instruction is a load or store (Mem_R_EN or Mem_W_EN)
- branch_taken  in  1  B resolved taken in EXE
- fwd_en  in  1  forwarding unit enabled
- clr_stats  in  1  synchronous clear of stall_count
- hazard_stall  out  1  freeze PC and IF/ID; flush ID/EX (bubble)
- if_flush  out  1  flush IF/ID
- id_flush  out  1  flush ID/EX
- mem_freeze  out  1  freeze all pipeline registers and PC
- mem_busy  out  1  FSM in BUSY state (registered)
- stall_count  out  CNT_W  cycles with hazard_stall or mem_freeze set

Behaviour:
- Reset:
  - While rst = 0: FSM is IDLE, wait counter is 0, stall_count is 0, mem_busy is 0.
  - All combinational outputs (hazard_stall, if_flush, id_flush, mem_freeze) are forced to 0 while rst = 0, regardless of inputs.
  - Reset asserted mid-BUSY aborts immediately; no state is retained.
- Hazard detection (combinational):
  - Match term m(r, d) = (r == d).
  - Per-source qualifiers: src1 counts only if src_valid = 1; src2 counts only if two_src = 1.
  - fwd_en = 1: raw = exe_mem_r_en & (m(src1, exe_dest) | m(src2, exe_dest)). This is the load-use hazard only.
  - fwd_en = 0: raw = (exe_wb_en & match on exe_dest) | (mem_wb_en & match on mem_dest).
- Branch: if_flush = id_flush = branch_taken, combinational and same cycle.
- Memory FSM, state IDLE:
  - mem_freeze = mem_req when MEM_LAT > 1; otherwise 0.
  - If mem_req = 1 and MEM_LAT > 1: go to BUSY with cnt <= MEM_LAT-2.
- Memory FSM, state BUSY:
  - mem_freeze = (cnt != 0). cnt decrements each cycle.
  - When cnt == 0: mem_freeze = 0, the pipeline advances at that edge, next state is IDLE.
  - Net effect: exactly MEM_LAT-1 freeze cycles per memory instruction.
  - Back-to-back memory instructions each incur the full freeze. There is no idle gap cycle.
- Priority:
  - mem_freeze = 1 forces hazard_stall, if_flush and id_flush to 0. Frozen stages hold their inputs, so these re-evaluate when the freeze drops.
  - Otherwise branch_taken overrides the hazard: hazard_stall = raw & ~branch_taken. The stalled instruction is being flushed anyway.
- hazard_stall lasts exactly as long as the input match persists. With fwd_en = 1 this is 1 cycle; with fwd_en = 0 it is up to 2 cycles. It is not registered.
- stall_count:
  - At each posedge, if clr_stats = 1 the counter clears. clr_stats has priority over increment.
  - Otherwise it increments if (hazard_stall | mem_freeze) = 1.
  - Saturates at all-ones; no wrap-around.
- mem_busy = (state == BUSY), registered.

Test Plan:
- Reset and IDLE behaviour: hold rst = 0 with mem_req = 1 and branch_taken = 1 -> all outputs 0. Release rst; mem_req = 1 for 1 cycle -> mem_freeze = 1 that cycle, then exactly 1 further freeze cycle with MEM_LAT = 3, mem_busy = 1 for 2 cycles, stall_count = 2.
- Load-use with forwarding: fwd_en = 1, exe_mem_r_en = 1, exe_dest = 4'd5, src1 = 4'd5, src_valid = 1 -> hazard_stall = 1. Set src_valid = 0 -> hazard_stall = 0. Set two_src = 1, src2 = 4'd5 -> hazard_stall = 1.
- No forwarding: fwd_en = 0, mem_wb_en = 1, mem_dest = 4'd3, src2 = 4'd3, two_src = 1 -> hazard_stall = 1. Set exe_mem_r_en = 0 with exe_wb_en = 1 and exe_dest = 4'd7 = src1 -> hazard_stall = 1.
- Priority:
  - branch_taken = 1 together with a load-use hazard -> if_flush = id_flush = 1, hazard_stall = 0.
  - Then assert mem_req with MEM_LAT = 3 -> all flushes and hazard_stall are suppressed for 2 cycles; the flush is reissued in the cycle mem_freeze drops.
- Back-to-back memory: mem_req held high for 2 consecutive instructions, MEM_LAT = 4 -> freeze pattern 1,1,1,0,1,1,1,0. Assert rst = 0 mid-BUSY -> mem_freeze = 0 and mem_busy = 0 immediately.
- Counter: force continuous stall with CNT_W = 4 -> stall_count saturates at 15. Pulse clr_stats during an active stall -> stall_count = 0 next cycle.
